icb_fill_master: RTL and testbench

ICB_FILL_MASTER -- requirements
Module: icb_fill_master

---
 rtl/icb_fill_master.sv | 250 +++++++++++++++++++++++++
 tb/tb_icb_fill_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icb_fill_master.sv
// ICB fill master: streams constant/incrementing writes (or reads) over an address range.
// Define BIU_FILL_VERIFY_EN to compare read-back data in mode 10; otherwise mode 10 behaves as mode 00.

module icb_fill_master #(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_OUTS = 4,
  parameter int unsigned STRIDE   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [CNT_W-1:0]    word_cnt,
  input  logic [DATA_W-1:0]   pattern,
  input  logic [DATA_W/8-1:0] wmask,
  input  logic [1:0]          mode,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CNT_W-1:0]    err_cnt,
  output logic                icb_cmd_vld,
  input  logic                icb_cmd_rdy,
  output logic [ADDR_W-1:0]   icb_cmd_addr,
  output logic                icb_cmd_read,
  output logic [DATA_W-1:0]   icb_cmd_wdata,
  output logic [DATA_W/8-1:0] icb_cmd_wmask,
  input  logic                icb_rsp_vld,
  output logic                icb_rsp_rdy,
  input  logic [DATA_W-1:0]   icb_rsp_rdata,
  input  logic                icb_rsp_err
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned OUTS_W = $clog2(MAX_OUTS + 1);
  localparam logic [OUTS_W-1:0] MAX_OUTS_V = OUTS_W'(MAX_OUTS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_ptr_q, addr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] pattern_q, pattern_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic              inc_mode_q, inc_mode_d;
  logic [CNT_W-1:0]  issue_idx_q, issue_idx_d;
  logic [CNT_W-1:0]  rsp_idx_q, rsp_idx_d;
  logic [OUTS_W-1:0] outs_q, outs_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cmd_vld_q, cmd_vld_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic              cmd_read_q, cmd_read_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [MASK_W-1:0] cmd_wmask_q, cmd_wmask_d;

  logic cmd_hs;
  logic rsp_fire;
  logic rsp_bad;
  logic start_rd;
  logic rd_mode_q;
  logic vfy_miss;

`ifdef BIU_FILL_VERIFY_EN
  // Read-verify mode: each response must return pattern + response index.
  assign start_rd = (mode == 2'b10);
  assign vfy_miss = rd_mode_q & (icb_rsp_rdata != (pattern_q + DATA_W'(rsp_idx_q)));

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_mode_q <= 1'b0;
    end else if ((state_q == S_IDLE) && start) begin
      rd_mode_q <= start_rd;
    end
  end
`else
  logic unused_rdata;
  assign start_rd     = 1'b0;
  assign rd_mode_q    = 1'b0;
  assign vfy_miss     = 1'b0;
  assign unused_rdata = ^icb_rsp_rdata;
`endif

  assign cmd_hs   = cmd_vld_q & icb_cmd_rdy;
  // Responses only count while a transfer owns the bus; strays after reset are dropped.
  assign rsp_fire = icb_rsp_vld & ((state_q == S_ISSUE) | (state_q == S_DRAIN)) & (outs_q != '0);
  assign rsp_bad  = rsp_fire & (icb_rsp_err | vfy_miss);

  always_comb begin
    state_d     = state_q;
    addr_ptr_d  = addr_ptr_q;
    cnt_d       = cnt_q;
    pattern_d   = pattern_q;
    wmask_d     = wmask_q;
    inc_mode_d  = inc_mode_q;
    issue_idx_d = issue_idx_q;
    rsp_idx_d   = rsp_idx_q;
    outs_d      = outs_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    cmd_vld_d   = cmd_vld_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_read_d  = cmd_read_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_wmask_d = cmd_wmask_q;

    if (rsp_fire) begin
      rsp_idx_d = rsp_idx_q + CNT_W'(1);
    end
    if (rsp_bad) begin
      err_d = 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        cmd_vld_d   = 1'b0;
        cmd_addr_d  = '0;
        cmd_read_d  = 1'b1;
        cmd_wdata_d = '0;
        cmd_wmask_d = '0;
        if (start) begin
          addr_ptr_d  = start_addr;
          cnt_d       = word_cnt;
          pattern_d   = pattern;
          wmask_d     = wmask;
          inc_mode_d  = (mode == 2'b01);
          issue_idx_d = '0;
          rsp_idx_d   = '0;
          outs_d      = '0;
          err_d       = 1'b0;
          err_cnt_d   = '0;
          if (word_cnt == '0) begin
            state_d = S_DONE;
          end else begin
            // Command 0 is presented in the first ISSUE cycle.
            state_d     = S_ISSUE;
            cmd_vld_d   = 1'b1;
            cmd_addr_d  = start_addr;
            cmd_read_d  = start_rd;
            cmd_wdata_d = start_rd ? '0 : pattern;
            cmd_wmask_d = wmask;
          end
        end
      end
      S_ISSUE: begin
        outs_d = outs_q + OUTS_W'(cmd_hs) - OUTS_W'(rsp_fire);
        if (cmd_hs) begin
          issue_idx_d = issue_idx_q + CNT_W'(1);
          addr_ptr_d  = addr_ptr_q + ADDR_W'(STRIDE);
        end
        // A presented command holds until accepted.
        if (!cmd_vld_q || icb_cmd_rdy) begin
          cmd_vld_d   = 1'b0;
          cmd_addr_d  = '0;
          cmd_read_d  = 1'b1;
          cmd_wdata_d = '0;
          cmd_wmask_d = '0;
          if (issue_idx_d == cnt_q) begin
            state_d = S_DRAIN;
          end else if (outs_d < MAX_OUTS_V) begin
            cmd_vld_d   = 1'b1;
            cmd_addr_d  = addr_ptr_d;
            cmd_read_d  = rd_mode_q;
            cmd_wdata_d = rd_mode_q  ? '0 :
                          inc_mode_q ? (pattern_q + DATA_W'(issue_idx_d)) : pattern_q;
            cmd_wmask_d = wmask_q;
          end
        end
      end
      S_DRAIN: begin
        outs_d = outs_q - OUTS_W'(rsp_fire);
        if (outs_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_ptr_q  <= '0;
      cnt_q       <= '0;
      pattern_q   <= '0;
      wmask_q     <= '0;
      inc_mode_q  <= 1'b0;
      issue_idx_q <= '0;
      rsp_idx_q   <= '0;
      outs_q      <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_vld_q   <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_read_q  <= 1'b1;
      cmd_wdata_q <= '0;
      cmd_wmask_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_ptr_q  <= addr_ptr_d;
      cnt_q       <= cnt_d;
      pattern_q   <= pattern_d;
      wmask_q     <= wmask_d;
      inc_mode_q  <= inc_mode_d;
      issue_idx_q <= issue_idx_d;
      rsp_idx_q   <= rsp_idx_d;
      outs_q      <= outs_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_vld_q   <= cmd_vld_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_read_q  <= cmd_read_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_wmask_q <= cmd_wmask_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_cnt       = err_cnt_q;
  assign icb_cmd_vld   = cmd_vld_q;
  assign icb_cmd_addr  = cmd_addr_q;
  assign icb_cmd_read  = cmd_read_q;
  assign icb_cmd_wdata = cmd_wdata_q;
  assign icb_cmd_wmask = cmd_wmask_q;
  assign icb_rsp_rdy   = 1'b1;

endmodule

// File: tb/tb_icb_fill_master.sv
// Directed bench for icb_fill_master: in-order responder with credit control and a command log.

module tb_icb_fill_master;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 16;
  localparam int unsigned MO = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [CW-1:0] word_cnt;
  logic [DW-1:0] pattern;
  logic [7:0]    wmask;
  logic [1:0]    mode;
  logic          busy, done, err;
  logic [CW-1:0] err_cnt;
  logic          icb_cmd_vld, icb_cmd_rdy, icb_cmd_read;
  logic [AW-1:0] icb_cmd_addr;
  logic [DW-1:0] icb_cmd_wdata;
  logic [7:0]    icb_cmd_wmask;
  logic          icb_rsp_vld, icb_rsp_rdy, icb_rsp_err;
  logic [DW-1:0] icb_rsp_rdata;

  icb_fill_master #(
    .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .MAX_OUTS(MO), .STRIDE(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .word_cnt(word_cnt), .pattern(pattern), .wmask(wmask), .mode(mode),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt),
    .icb_cmd_vld(icb_cmd_vld), .icb_cmd_rdy(icb_cmd_rdy),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_vld(icb_rsp_vld), .icb_rsp_rdy(icb_rsp_rdy),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] log_addr[$];
  logic [63:0] log_wdata[$];
  logic        log_read[$];
  logic [7:0]  log_mask[$];
  int          pend;
  int          credit;
  int          rsp_n;
  int          err_idx;
  bit          err_force;
  logic [63:0] rsp_pat;
  int          n_chk;
  int          n_pass;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock: log the handshake the next edge will take, then drive responses at the following negedge.
  task automatic cyc();
    if (icb_cmd_vld && icb_cmd_rdy) begin
      log_addr.push_back(icb_cmd_addr);
      log_wdata.push_back(icb_cmd_wdata);
      log_read.push_back(icb_cmd_read);
      log_mask.push_back(icb_cmd_wmask);
      pend++;
    end
    @(negedge clk);
    icb_rsp_vld   = 1'b0;
    icb_rsp_err   = 1'b0;
    icb_rsp_rdata = '0;
    if (pend > 0 && credit > 0) begin
      icb_rsp_vld   = 1'b1;
      icb_rsp_err   = err_force || (rsp_n == err_idx);
      icb_rsp_rdata = rsp_pat + 64'(rsp_n);
      rsp_n++;
      pend--;
      credit--;
    end
  endtask

  task automatic start_xfer(input logic [63:0] a, input logic [15:0] n, input logic [63:0] p,
                            input logic [7:0] m, input logic [1:0] md);
    log_addr.delete();
    log_wdata.delete();
    log_read.delete();
    log_mask.delete();
    rsp_n      = 0;
    rsp_pat    = p;
    start      = 1'b1;
    start_addr = a;
    word_cnt   = n;
    pattern    = p;
    wmask      = m;
    mode       = md;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    chk({tag, "_done"}, 64'(ok), 64'd1);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_vld"},     64'(icb_cmd_vld),   64'd0);
    chk({p, "_addr"},    icb_cmd_addr,       64'd0);
    chk({p, "_read"},    64'(icb_cmd_read),  64'd1);
    chk({p, "_wdata"},   icb_cmd_wdata,      64'd0);
    chk({p, "_wmask"},   64'(icb_cmd_wmask), 64'd0);
    chk({p, "_busy"},    64'(busy),          64'd0);
    chk({p, "_done"},    64'(done),          64'd0);
    chk({p, "_err"},     64'(err),           64'd0);
    chk({p, "_errcnt"},  64'(err_cnt),       64'd0);
    chk({p, "_rsp_rdy"}, 64'(icb_rsp_rdy),   64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; pend = 0; credit = 1000; rsp_n = 0;
    err_idx = -1; err_force = 1'b0; rsp_pat = '0;
    rst = 1'b1; start = 1'b0; start_addr = '0; word_cnt = '0; pattern = '0;
    wmask = '0; mode = 2'b00; icb_cmd_rdy = 1'b1;
    icb_rsp_vld = 1'b0; icb_rsp_err = 1'b0; icb_rsp_rdata = '0;
    repeat (2) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;
    cyc();

    // Constant fill, one-cycle response latency.
    start_xfer(64'hA100_0000, 16'd3, 64'h00FF_00FF_00FF_00FF, 8'hFF, 2'b00);
    wait_done("const");
    chk("const_n", 64'(log_addr.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("const_addr%0d", i), log_addr[i], 64'hA100_0000 + 64'(4 * i));
      chk($sformatf("const_wd%0d", i), log_wdata[i], 64'h00FF_00FF_00FF_00FF);
      chk($sformatf("const_rd%0d", i), 64'(log_read[i]), 64'd0);
      chk($sformatf("const_mk%0d", i), 64'(log_mask[i]), 64'hFF);
    end
    chk("const_err", 64'(err), 64'd0);
    chk("const_busy_at_done", 64'(busy), 64'd1);
    cyc();
    chk("const_done_pulse", 64'(done), 64'd0);
    chk("const_idle_busy", 64'(busy), 64'd0);

    // Incrementing fill; a second start mid-run must be ignored.
    start_xfer(64'h2000, 16'd4, 64'h10, 8'h0F, 2'b01);
    cyc();
    start = 1'b1; start_addr = 64'h5000;
    cyc();
    start = 1'b0;
    wait_done("inc");
    chk("inc_n", 64'(log_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("inc_wd%0d", i), log_wdata[i], 64'h10 + 64'(i));
      chk($sformatf("inc_addr%0d", i), log_addr[i], 64'h2000 + 64'(4 * i));
    end
    cyc();

    // Outstanding limit: responses withheld, then one released.
    credit = 0;
    start_xfer(64'h3000, 16'd4, 64'h77, 8'h0F, 2'b00);
    cyc();
    cyc();
    chk("outs_hs2", 64'(log_addr.size()), 64'd2);
    chk("outs_vld_drop", 64'(icb_cmd_vld), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("outs_vld_low%0d", i), 64'(icb_cmd_vld), 64'd0);
    end
    credit = 1;
    cyc();
    chk("outs_rsp_driven", 64'(icb_rsp_vld), 64'd1);
    chk("outs_vld_rsp_cycle", 64'(icb_cmd_vld), 64'd0);
    cyc();
    chk("outs_reissue_vld", 64'(icb_cmd_vld), 64'd1);
    chk("outs_reissue_addr", icb_cmd_addr, 64'h3008);
    credit = 1000;
    wait_done("outs");
    chk("outs_n", 64'(log_addr.size()), 64'd4);
    cyc();

    // Back-pressure: command must hold while rdy is low.
    icb_cmd_rdy = 1'b0;
    start_xfer(64'h4000, 16'd2, 64'hAB, 8'h3C, 2'b00);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("stall_vld%0d", i), 64'(icb_cmd_vld), 64'd1);
      chk($sformatf("stall_addr%0d", i), icb_cmd_addr, 64'h4000);
      chk($sformatf("stall_wd%0d", i), icb_cmd_wdata, 64'hAB);
    end
    chk("stall_no_hs", 64'(log_addr.size()), 64'd0);
    icb_cmd_rdy = 1'b1;
    wait_done("stall");
    chk("stall_n", 64'(log_addr.size()), 64'd2);
    chk("stall_addr1", log_addr[1], 64'h4004);
    chk("stall_mask1", 64'(log_mask[1]), 64'h3C);
    cyc();

    // Address wrap.
    start_xfer(64'hFFFF_FFFF_FFFF_FFFC, 16'd2, 64'h1, 8'h01, 2'b00);
    wait_done("wrap");
    chk("wrap_addr0", log_addr[0], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr1", log_addr[1], 64'h0);
    cyc();

    // Zero-length request goes straight to a done pulse.
    start_xfer(64'h9000, 16'd0, 64'h5, 8'hFF, 2'b00);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd1);
    chk("zero_vld", 64'(icb_cmd_vld), 64'd0);
    cyc();
    chk("zero_done_end", 64'(done), 64'd0);
    chk("zero_busy_end", 64'(busy), 64'd0);

    // Mode 10.
    start_xfer(64'h6000, 16'd2, 64'h55, 8'hFF, 2'b10);
    wait_done("m10");
    chk("m10_err", 64'(err), 64'd0);
`ifdef BIU_FILL_VERIFY_EN
    chk("m10_read", 64'(log_read[1]), 64'd1);
    chk("m10_wd", log_wdata[1], 64'd0);
`else
    chk("m10_read", 64'(log_read[1]), 64'd0);
    chk("m10_wd", log_wdata[1], 64'h55);
`endif
    cyc();

    // Error on second response, then reset mid-transfer.
    err_idx = 1;
    start_xfer(64'h7000, 16'd3, 64'h99, 8'hFF, 2'b00);
    wait_done("rerr");
    chk("rerr_err", 64'(err), 64'd1);
    chk("rerr_errcnt", 64'(err_cnt), 64'd1);
    cyc();
    err_idx = -1;
    start_xfer(64'h8000, 16'd4, 64'h42, 8'hFF, 2'b00);
    cyc();
    cyc();
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_reset("mid_rst");
    err_force = 1'b1;
    pend = pend + 2;
    for (int i = 0; i < 4; i++) cyc();
    chk("stray_err", 64'(err), 64'd0);
    chk("stray_errcnt", 64'(err_cnt), 64'd0);
    chk("stray_busy", 64'(busy), 64'd0);
    chk("stray_vld", 64'(icb_cmd_vld), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
